// File: rtl/sfx_pkg.sv
// sfx_pkg: shared FSM states, ROM geometry and note codes for the sound-effect player.
package sfx_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} sfx_state_e;
    localparam int SFX_ADDR_W = 7;
    localparam int SFX_ROM_DEPTH = 128;
    localparam logic [7:0] NOTE_REST = 8'h00;
    localparam logic [7:0] NOTE_END = 8'hFF;
endpackage

// File: rtl/sfx_tone_gen.sv
// sfx_tone_gen: half-period counter plus toggle flop producing a square wave of note*PRESCALE clocks per half period.
module sfx_tone_gen
    import sfx_pkg::*;
#(
    parameter int PRESCALE = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] note,
    output logic       audio
);
    localparam int HW = 8 + $clog2(PRESCALE);
    logic [HW-1:0] cnt_q, cnt_d, last;
    logic audio_q, audio_d, off, wrap;
    always_comb begin
        last = HW'(note) * HW'(PRESCALE) - HW'(1);
        off = clr || !en || note == NOTE_REST;
        wrap = cnt_q == last;
        cnt_d = off || wrap ? '0 : cnt_q + HW'(1);
        audio_d = off ? 1'b0 : audio_q ^ wrap;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            audio_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            audio_q <= audio_d;
        end
    end
    assign audio = audio_q;
endmodule

// File: rtl/sfx_player.sv
// sfx_player: steps through sfx_rom from address 0 and plays each note byte as a square wave.
// Optional macro SFX_LOOP_EN: the end of the effect restarts at address 0 instead of returning to idle.
module sfx_player
    import sfx_pkg::*;
#(
    parameter int PRESCALE = 64,
    parameter int NOTE_CYCLES = 1500000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trigger,
    input  logic                  stop,
    output logic [SFX_ADDR_W-1:0] rom_addr,
    input  logic [7:0]            note_in,
    output logic                  audio,
    output logic                  busy
);
    localparam int DW = $clog2(NOTE_CYCLES);
`ifdef SFX_LOOP_EN
    localparam sfx_state_e END_STATE = FETCH;
`else
    localparam sfx_state_e END_STATE = IDLE;
`endif
    sfx_state_e state_q, state_d;
    logic [SFX_ADDR_W-1:0] addr_q, addr_d;
    logic [7:0] note_q, note_d;
    logic [DW-1:0] dur_q, dur_d;
    logic end_note, last_dur;
    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        note_d = note_q;
        end_note = 1'b0;
        last_dur = dur_q == DW'(NOTE_CYCLES - 1);
        case (state_q)
            IDLE: if (trigger) begin
                state_d = FETCH;
                addr_d = '0;
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                note_d = note_in;
                if (note_in == NOTE_END) end_note = 1'b1;
                else state_d = PLAY;
            end
            PLAY: if (last_dur) begin
                if (addr_q == SFX_ADDR_W'(SFX_ROM_DEPTH - 1)) end_note = 1'b1;
                else begin
                    addr_d = addr_q + SFX_ADDR_W'(1);
                    state_d = FETCH;
                end
            end
        endcase
        if (end_note) begin
            state_d = END_STATE;
            addr_d = '0;
        end
        if (trigger && state_q != IDLE) begin
            state_d = FETCH;
            addr_d = '0;
        end
        // stop has the final say, so it beats a same-cycle trigger
        if (stop) begin
            state_d = IDLE;
            addr_d = '0;
        end
        dur_d = state_q == PLAY && state_d == PLAY ? dur_q + DW'(1) : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q <= '0;
            note_q <= '0;
            dur_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            note_q <= note_d;
            dur_q <= dur_d;
        end
    end
    sfx_tone_gen #(.PRESCALE(PRESCALE)) u_tone (
        .clk(clk),
        .rst(rst),
        .clr(state_d != PLAY),
        .en(state_q == PLAY),
        .note(note_q),
        .audio(audio)
    );
    assign rom_addr = addr_q;
    assign busy = state_q != IDLE;
endmodule

// File: tb/tb_sfx_player.sv
// tb_sfx_player: directed scenarios plus randomized episodes checked every cycle against a timeline model.
module tb_sfx_player;
    localparam int PRE = 2;
    localparam int NC = 16;
    localparam int NS = NC + 2;
`ifdef SFX_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, trigger = 1'b0, stop = 1'b0;
    logic [6:0] rom_addr;
    logic [7:0] note_in = 8'h00;
    logic audio, busy;
    logic [7:0] rom [128];
    int n_cmp = 0, n_bad = 0;
    bit chk_en = 1'b0;
    bit m_act = 1'b0;
    int m_k = 0;

    sfx_player #(.PRESCALE(PRE), .NOTE_CYCLES(NC)) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .stop(stop),
        .rom_addr(rom_addr), .note_in(note_in), .audio(audio), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) note_in <= rom[rom_addr];

    // Model: m_k counts cycles since the current pass through the ROM began;
    // each note occupies NS cycles: fetch, load, then NC cycles of play.
    always @(posedge clk) begin : model
        bit na;
        int nk;
        na = m_act;
        nk = m_act ? m_k + 1 : 0;
        if (rst || stop) na = 1'b0;
        else if (trigger) begin
            na = 1'b1;
            nk = 0;
        end else if (m_act && ((m_k % NS == 1 && rom[m_k / NS] == 8'hFF) || m_k == 128 * NS - 1)) begin
            na = LOOP;
            nk = 0;
        end
        m_act <= na;
        m_k <= nk;
    end

    function automatic int exp_addr();
        return m_act ? m_k / NS : 0;
    endfunction

    function automatic int exp_audio();
        int off, n;
        if (!m_act) return 0;
        off = m_k % NS;
        n = int'(rom[m_k / NS]);
        if (off < 2 || n == 0) return 0;
        return ((off - 2) / (n * PRE)) % 2;
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp_v);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("busy", int'(busy), int'(m_act));
        chk("rom_addr", int'(rom_addr), exp_addr());
        chk("audio", int'(audio), exp_audio());
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_rom(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        for (int i = 0; i < 128; i++) rom[i] = 8'h55;
        rom[0] = a;
        rom[1] = b;
        rom[2] = c;
    endtask

    // Sets trigger on the current negedge; on return we sit in cycle t+1 (FETCH).
    task automatic fire();
        trigger = 1'b1;
        cyc(1);
        trigger = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        cyc(2);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 8'h00;
        cyc(3);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset busy", int'(busy), 0);
        chk("reset addr", int'(rom_addr), 0);
        chk("reset audio", int'(audio), 0);
        cyc(1);

        // tone timing: N=3 gives a 6-clock half period
        load_rom(8'h03, 8'hFF, 8'h55);
        fire();
        chk("tone busy t+1", int'(busy), 1);
        cyc(7);
        chk("tone audio t+8", int'(audio), 0);
        cyc(1);
        chk("tone audio t+9", int'(audio), 1);
        cyc(6);
        chk("tone audio t+15", int'(audio), 0);
        cyc(4);
        chk("tone addr t+19", int'(rom_addr), 1);
        cyc(2);
`ifdef SFX_LOOP_EN
        chk("tone loop busy t+21", int'(busy), 1);
        halt();
`else
        chk("tone idle busy t+21", int'(busy), 0);
        chk("tone idle addr t+21", int'(rom_addr), 0);
        cyc(2);
`endif

        // rest then a 2-clock half-period tone
        load_rom(8'h00, 8'h01, 8'hFF);
        fire();
        cyc(9);
        chk("rest audio t+10", int'(audio), 0);
        cyc(11);
        chk("rest addr t+21", int'(rom_addr), 1);
        chk("rest audio t+21", int'(audio), 0);
        cyc(2);
        chk("rest audio t+23", int'(audio), 1);
        cyc(14);
        chk("rest addr t+37", int'(rom_addr), 2);
        cyc(4);
        halt();

        // full sweep through every address
        load_rom(8'h55, 8'h55, 8'h55);
        fire();
        cyc(128 * NS - 1);
        chk("sweep addr last", int'(rom_addr), 127);
        chk("sweep busy last", int'(busy), 1);
        cyc(1);
`ifdef SFX_LOOP_EN
        chk("sweep wrap busy", int'(busy), 1);
        chk("sweep wrap addr", int'(rom_addr), 0);
        halt();
`else
        chk("sweep end busy", int'(busy), 0);
        cyc(20);
        chk("sweep no refetch", int'(rom_addr), 0);
`endif

        // stop mid-play, then stop+trigger together, then restart mid-note
        load_rom(8'h01, 8'h02, 8'hFF);
        fire();
        cyc(4);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("stop busy", int'(busy), 0);
        chk("stop audio", int'(audio), 0);
        fire();
        cyc(5);
        stop = 1'b1;
        trigger = 1'b1;
        cyc(1);
        stop = 1'b0;
        trigger = 1'b0;
        chk("stop+trig busy", int'(busy), 0);
        cyc(2);
        fire();
        cyc(24);
        chk("pre-restart addr", int'(rom_addr), 1);
        fire();
        chk("restart addr", int'(rom_addr), 0);
        chk("restart busy", int'(busy), 1);
        cyc(5);
        halt();

        // reset while audio is high
        load_rom(8'h01, 8'hFF, 8'h55);
        fire();
        cyc(4);
        chk("pre-rst audio", int'(audio), 1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst busy", int'(busy), 0);
        chk("rst audio", int'(audio), 0);
        chk("rst addr", int'(rom_addr), 0);
        fire();
        cyc(30);

`ifdef SFX_LOOP_EN
        load_rom(8'h02, 8'hFF, 8'h55);
        fire();
        cyc(18);
        chk("loop addr 1", int'(rom_addr), 1);
        cyc(2);
        chk("loop addr 0", int'(rom_addr), 0);
        chk("loop busy", int'(busy), 1);
        cyc(40);
        halt();
        chk("loop stopped", int'(busy), 0);
`endif

        // randomized episodes; ROM only changes while the player is idle
        halt();
        for (int e = 0; e < 14; e++) begin
            for (int i = 0; i < 128; i++) rom[i] = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 3) != 0) rom[$urandom_range(0, 9)] = 8'hFF;
            fire();
            repeat ($urandom_range(60, 700)) begin
                trigger = $urandom_range(0, 99) == 0;
                stop = $urandom_range(0, 199) == 0;
                rst = $urandom_range(0, 399) == 0;
                cyc(1);
            end
            trigger = 1'b0;
            rst = 1'b0;
            halt();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
